// File: rtl/mux4_rr_arbiter.sv
// Four-way round-robin arbiter that steers one data lane onto a shared registered output.
// An owner keeps the grant until it releases, drops its request, or hits the hold limit.
module mux4_rr_arbiter #(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       rel,
    input  logic [3:0] d,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       valid,
    output logic       y
);

    // state | meaning
    // IDLE  | no owner; pick the next winner in pointer order on the next edge
    // GRANT | sel owns the channel; watch for release, request drop or hold limit
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    if (HOLD_MAX < 2 || HOLD_MAX > 15) begin : g_bad_hold
        $error("mux4_rr_arbiter: HOLD_MAX must be in 2..15");
    end
    if ((2 ** CNT_W) <= HOLD_MAX) begin : g_bad_cnt
        $error("mux4_rr_arbiter: CNT_W too narrow for HOLD_MAX");
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

    state_t           state;
    logic [1:0]       ptr;
    logic [CNT_W-1:0] cnt;

    logic       win_found;
    logic [1:0] win_idx;
    logic       grant_exit;

    // First asserted request starting at ptr and wrapping modulo 4.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr;
        for (int k = 0; k < 4; k++) begin
            if (!win_found && req[ptr + 2'(k)]) begin
                win_found = 1'b1;
                win_idx   = ptr + 2'(k);
            end
        end
    end

    assign grant_exit = rel || !req[sel] || (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= 2'd0;
            cnt   <= '0;
            gnt   <= 4'b0000;
            sel   <= 2'd0;
            valid <= 1'b0;
            y     <= 1'b0;
        end else begin
            y <= valid ? d[sel] : 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (win_found) begin
                        state <= GRANT;
                        gnt   <= 4'b0001 << win_idx;
                        sel   <= win_idx;
                        valid <= 1'b1;
                    end else begin
                        gnt   <= 4'b0000;
                        valid <= 1'b0;
                    end
                end
                GRANT: begin
                    if (grant_exit) begin
                        state <= IDLE;
                        gnt   <= 4'b0000;
                        valid <= 1'b0;
                        ptr   <= sel + 2'd1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= 4'b0000;
                    valid <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
